// File: rtl/uart_rx_engine_if.sv
// Register-side bundle of the UART receive engine: frame format,
// read strobe, received character and its status flags.
interface uart_rx_engine_if;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rxrdy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    modport master (
        output eight, pen, ohel, clr_rdy,
        input  rx_data, rxrdy, perr, ferr, ovf
    );

    modport slave (
        input  eight, pen, ohel, clr_rdy,
        output rx_data, rxrdy, perr, ferr, ovf
    );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchroniser, start qualification, bit shifting, status.
// Parity reception and checking is built only when RX_PARITY_EN is defined.
module uart_rx_engine (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              btu,
    output logic              start,
    output logic              doit,
    uart_rx_engine_if.slave   host
);
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [9:0]  shreg_q, shreg_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rxrdy_q, rxrdy_d;
    logic        ferr_q, ferr_d;
    logic        ovf_q, ovf_d;

    logic        rx_s;
    logic        done;
    logic        pen_eff;
    logic [3:0]  frame_len;
    logic [9:0]  frame;
    logic [7:0]  data_bits;
    logic        unused_frame;

    assign rx_s = sync2_q;

`ifdef RX_PARITY_EN
    logic perr_q, perr_d;
    logic par_bit;
    logic perr_new;

    assign pen_eff = host.pen;
`else
    logic unused_cfg;

    assign pen_eff    = 1'b0;
    assign unused_cfg = host.pen ^ host.ohel;
`endif

    assign frame_len = 4'd8 + {3'b000, host.eight} + {3'b000, pen_eff};

    always_comb begin
        sync1_d  = rx;
        sync2_d  = sync1_q;
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                bitcnt_d = '0;
                shreg_d  = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (btu) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (btu) begin
                    shreg_d  = {rx_s, shreg_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_d == frame_len) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Right-justify the frame so the first data bit lands in bit 0.
    always_comb begin
        frame     = shreg_d >> (4'd10 - frame_len);
        data_bits = host.eight ? frame[7:0]
                               : {1'b0, frame[6:0]};
    end

    assign unused_frame = ^frame[9:8];

`ifdef RX_PARITY_EN
    always_comb begin
        par_bit  = host.eight ? frame[8] : frame[7];
        perr_new = pen_eff
                 & ((^data_bits ^ par_bit) != host.ohel);
    end
`endif

    // A completing frame takes priority over a simultaneous read strobe.
    always_comb begin
        rx_data_d = rx_data_q;
        rxrdy_d   = rxrdy_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
`ifdef RX_PARITY_EN
        perr_d    = perr_q;
`endif
        if (done) begin
            rx_data_d = data_bits;
            rxrdy_d   = 1'b1;
            ferr_d    = ~shreg_d[9];
            ovf_d     = rxrdy_q & ~host.clr_rdy;
`ifdef RX_PARITY_EN
            perr_d    = perr_new;
`endif
        end else if (host.clr_rdy) begin
            rxrdy_d = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
`ifdef RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            rx_data_q <= 8'h00;
            rxrdy_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            rx_data_q <= rx_data_d;
            rxrdy_q   <= rxrdy_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign host.perr = perr_q;
`else
    assign host.perr = 1'b0;
`endif

    assign start        = (state_q == START);
    assign doit         = (state_q != IDLE);
    assign host.rx_data = rx_data_q;
    assign host.rxrdy   = rxrdy_q;
    assign host.ferr    = ferr_q;
    assign host.ovf     = ovf_q;

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

UART receive engine: the control, shifting and status stage that drives the receive bit-time counter and consumes its bit-time-up pulse. It synchronises the serial line and qualifies the start bit at mid-bit. It then samples 7/8 data bits, optional parity and the stop bit at bit centres. Finally it presents a parallel byte with ready, parity, framing and overrun flags to the register interface.

## Interface
- No parameters; frame format is selected at run time by ports.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- btu  input  1  bit-time-up pulse from the receive bit-time counter; one clk wide.
- eight  input  1  1 = 8 data bits, 0 = 7 data bits.
- pen  input  1  parity enable.
- ohel  input  1  parity sense: 0 = even, 1 = odd.
- clr_rdy  input  1  read strobe from the host; clears rxrdy and all error flags.
- start  output  1  to the counter: selects the half-bit terminal count.
- doit  output  1  to the counter: enables counting; 0 holds the counter at 0.
- rx_data  output  8  received character; bit 7 forced 0 in 7-bit mode.
- rxrdy  output  1  character available.
- perr  output  1  parity error.
- ferr  output  1  framing error (stop bit sampled 0).
- ovf  output  1  overrun (a new character completed while rxrdy = 1).

## Operation
- Input path: rx passes through a 2-flop synchroniser; both flops reset to 1; the result is rx_s. All decisions use rx_s.
- FSM states: IDLE, START, DATA. It is Moore: start = (state==START); doit = (state!=IDLE).
- IDLE: rx_s==0 → START. The bit counter and shift register are cleared.
- START (half-bit wait): on btu, rx_s==0 → DATA; rx_s==1 → IDLE (false start, no status change).
- DATA: on each btu, shift rx_s into a 10-bit shift register (shift right, new bit at MSB) and increment the 4-bit bit counter.
- Frame length after the start bit: N = 7 + eight + pen + 1, giving a range of 8..10.
- When the counter reaches N on a btu: return to IDLE and perform the completion update.
- Completion update: the frame is right-justified so the first data bit is rx_data[0].
  - Data bits go to rx_data[6:0] or rx_data[7:0].
  - The parity bit, if present, follows the last data bit.
  - The last sampled bit is the stop bit.
- ferr = ~stop bit.
- perr = pen & (XOR of data bits and the parity bit != ohel).
- rxrdy is set to 1.
- ovf is set if rxrdy was already 1 and clr_rdy is not asserted in the same cycle.
- clr_rdy clears rxrdy, perr, ferr and ovf. If it coincides with a completion update, the update wins: the flags are loaded with the new frame's values and ovf = 0.
- rx_data holds until the next completion and is unaffected by clr_rdy.
- Reset values:
  - state = IDLE; start = 0; doit = 0.
  - rx_data = 8'h00; rxrdy = perr = ferr = ovf = 0.
  - Shift register and bit counter = 0; synchroniser flops = 1.
- Reset mid-frame: the frame is abandoned and all of the above values are restored.
- The 4-bit bit counter never wraps: the FSM leaves DATA at N ≤ 10.

## Timing
- rx falling edge to start/doit high: 3 clk (2 synchroniser + 1 state register).
- start qualification: the first btu after entering START, at the half-bit point.
- Every subsequent btu samples at the centre of a bit.
- Final btu at cycle t → rx_data, rxrdy and flags valid at t+1; state IDLE and doit = 0 at t+1.
- The earliest next start detection is at t+1 if rx_s is already 0.
- btu is ignored in IDLE. btu arriving in the same cycle as a START→IDLE abort has no effect on status.
- eight, pen and ohel must be stable from START entry to completion; changes mid-frame are undefined.

## Configuration
- RX_PARITY_EN defined: parity is received and checked as above.
- RX_PARITY_EN undefined:
  - pen and ohel are ignored and treated as pen = 0, so N = 7 + eight + 1.
  - perr is tied to 0 and no parity XOR logic is built.

## Test plan
- Assert reset mid-frame, hold 2 clk, release → start = 0, doit = 0, rxrdy = 0, rx_data = 8'h00. The next frame is received correctly.
- Send 8N1 frame 0xA5 (eight = 1, pen = 0), btu every 16 clk (8 clk for the half bit) → rx_data = 8'hA5, rxrdy = 1, perr = 0, ferr = 0, ovf = 0.
- Pulse rx low for 4 clk, high before the half-bit btu → FSM returns to IDLE, doit = 0, rxrdy stays 0.
- Send 8E1 frame with data 0x03 and parity bit 1 (RX_PARITY_EN defined) → rx_data = 8'h03, perr = 1.
- Send 7O1 frame with data 0x41 and parity bit 1 → rx_data = 8'h41, perr = 0.
  - Without RX_PARITY_EN, eight = 0, pen = 1: the parity bit is taken as the stop bit and ferr follows it.
- Send 0x55 with stop bit 0 → ferr = 1.
  - Without clr_rdy, send 0x0F → rx_data = 8'h0F, ovf = 1, ferr = 0.
  - Then pulse clr_rdy → rxrdy = ovf = perr = ferr = 0.
